// File: rtl/seq_priority_encoder_pkg.sv
// Shared types and helpers for the sequential priority encoder slice.
// Optional feature macro: ENC_ZERO_BEAT_EN (adds the all-zero beat and out_zero).
package enc_pkg;

    // Default width of the request vector.
    localparam int ENC_N = 4;

    // Encoder FSM states, also used to present the state on the debug port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ZERO = 2'd2
    } enc_state_t;

    // Index of the lowest set bit of a vector of up to 32 bits.
    // Returns 0 for an all-zero vector.
    function automatic logic [4:0] lsb_index(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seq_priority_encoder_if.sv
// Handshake bundle between a request source, the encoder and an index consumer.
// Optional feature macro: ENC_ZERO_BEAT_EN (adds out_zero).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holding valid must keep its payload stable until
// that transfer; ready may change freely and never depends on valid.
interface seq_priority_encoder_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
`ifdef ENC_ZERO_BEAT_EN
    logic         out_zero;
`endif

    // Source/consumer side of the encoder.
    modport master (
        output in_valid,
        output in_vec,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_last,
`ifdef ENC_ZERO_BEAT_EN
        input  out_zero,
`endif
        output out_ready
    );

    // Encoder side.
    modport slave (
        input  in_valid,
        input  in_vec,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_last,
`ifdef ENC_ZERO_BEAT_EN
        output out_zero,
`endif
        input  out_ready
    );

endinterface

// File: rtl/seq_priority_encoder_lsb_onehot_find.sv
// Combinational lowest-set-bit finder: one-hot mask and binary index.
module lsb_onehot_find
    import enc_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx
);

    // Two's-complement trick isolates the lowest set bit; the index comes
    // from the shared package helper so every user agrees on bit order.
    always_comb begin
        onehot = vec & (~vec + N'(1));
        idx    = W'(lsb_index(32'(vec)));
    end

endmodule

// File: rtl/seq_priority_encoder.sv
// Sequential N-to-log2(N) encoder: takes a multi-hot vector and streams the
// index of each set bit, lowest first, one beat per accepted out_ready.
// Optional feature macro: ENC_ZERO_BEAT_EN (all-zero vector yields one beat
// flagged with out_zero instead of being silently dropped).
module seq_priority_encoder
    import enc_pkg::*;
#(
    parameter int N = ENC_N,
    localparam int W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_priority_encoder_if.slave bus,
    output enc_state_t           dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ZERO = 2'd2;

    logic [1:0]   state;
    logic [N-1:0] pend;
    logic [N-1:0] low_onehot;
    logic [W-1:0] low_idx;
    logic         single_bit;

    lsb_onehot_find #(
        .N (N),
        .W (W)
    ) u_find (
        .vec    (pend),
        .onehot (low_onehot),
        .idx    (low_idx)
    );

    // Outputs decode only from state and pend, so no input reaches an output
    // in the same cycle; pend is zero outside BUSY, which forces idx to 0.
    always_comb begin
        single_bit    = (pend != '0) && ((pend & (pend - N'(1))) == '0);
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_BUSY) || (state == ST_ZERO);
        bus.out_idx   = low_idx;
        bus.out_last  = ((state == ST_BUSY) && single_bit) || (state == ST_ZERO);
`ifdef ENC_ZERO_BEAT_EN
        bus.out_zero  = (state == ST_ZERO);
`endif
        dbg_state     = enc_state_t'(state);
    end

    // FSM and pending-bit register; reset discards any partially streamed vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pend  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (|bus.in_vec) begin
                            pend  <= bus.in_vec;
                            state <= ST_BUSY;
                        end else begin
`ifdef ENC_ZERO_BEAT_EN
                            state <= ST_ZERO;
`else
                            state <= ST_IDLE;
`endif
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.out_ready) begin
                        pend <= pend & ~low_onehot;
                        if (single_bit) state <= ST_IDLE;
                    end
                end
                ST_ZERO: begin
                    if (bus.out_ready) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    pend  <= '0;
                end
            endcase
        end
    end

endmodule
